// File: rtl/plic_src_cond.sv
// ---------------------------------------------------------------------------
// plic_src_cond
//
// Conditions raw asynchronous interrupt lines before they reach the PLIC
// core. For each source the raw line is polarity-corrected, passed through a
// SYNC_STAGES-deep synchronizer and then, optionally, debounced: the output
// only follows the synchronized level after it has been stable for
// DEBOUNCE_CYCLES consecutive cycles. A pulse that dies before qualifying
// sets a sticky per-source glitch flag.
//
// Configuration macro:
//   PLIC_SRC_DEBOUNCE_EN  defined   -> debounce counters and glitch flags
//                         undefined -> src is the last synchronizer stage,
//                                      glitch is tied low, glitch_clr and the
//                                      debounce parameters are ignored
//
// Parameters:
//   SOURCES          number of interrupt lines
//   SYNC_STAGES      synchronizer depth (2..4)
//   DEBOUNCE_CYCLES  stable cycles required before src changes (1..2**CNT_BITS)
//   CNT_BITS         width of each per-source debounce counter
//
// Ports:
//   PCLK        system clock, all state updates on its rising edge
//   PRESETn     asynchronous active-low reset
//   irq_raw     raw asynchronous interrupt lines
//   pol         per-source polarity, 1 = raw line is active-low
//   glitch_clr  per-source clear of the glitch flag
//   src         conditioned, registered interrupt sources to plic_core
//   glitch      sticky per-source "rejected pulse seen" flag
// ---------------------------------------------------------------------------
module plic_src_cond #(
  parameter int SOURCES         = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_BITS        = 3
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [SOURCES-1:0] irq_raw,
  input  logic [SOURCES-1:0] pol,
  input  logic [SOURCES-1:0] glitch_clr,
  output logic [SOURCES-1:0] src,
  output logic [SOURCES-1:0] glitch
);

  // Stage 0 samples the polarity-corrected line; a pol change therefore
  // looks exactly like an irq_raw change to everything downstream.
  logic [SYNC_STAGES-1:0][SOURCES-1:0] sync_q;
  logic [SOURCES-1:0]                  s;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw ^ pol};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef PLIC_SRC_DEBOUNCE_EN

  // Terminal count: reaching it with s still differing from src commits
  // the new level. With DEBOUNCE_CYCLES == 1 this is 0, so a difference
  // seen in the stable state commits on the very first edge.
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  // Per-source state is implicit: cnt == 0 is STABLE, cnt != 0 is QUALIFY.
  logic [SOURCES-1:0][CNT_BITS-1:0] cnt_q, cnt_d;
  logic [SOURCES-1:0]               src_q, src_d;
  logic [SOURCES-1:0]               glitch_q, glitch_d;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d    = cnt_q;
    src_d    = src_q;
    glitch_d = glitch_q & ~glitch_clr;
    for (int i = 0; i < SOURCES; i++) begin
      if (s[i] != src_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          src_d[i] = s[i];
          cnt_d[i] = '0;
        end else begin
          // Cannot wrap: cnt only increments while below CNT_LAST.
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (cnt_q[i] != '0) begin
        // Level fell back before qualifying: drop the count and flag it.
        // Written after the clear term, so a coincident set wins.
        cnt_d[i]    = '0;
        glitch_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q    <= '0;
      src_q    <= '0;
      glitch_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      glitch_q <= glitch_d;
    end
  end

  assign src    = src_q;
  assign glitch = glitch_q;

`else

  // Debounce removed: the last synchronizer flop is already registered.
  assign src    = s;
  assign glitch = '0;

  // Inputs and parameters that only matter to the debounce logic.
  logic                unused_glitch_clr;
  logic [CNT_BITS-1:0] unused_debounce_cfg;
  assign unused_glitch_clr   = ^glitch_clr;
  assign unused_debounce_cfg = CNT_BITS'(DEBOUNCE_CYCLES);

`endif

endmodule

// File: tb/tb_plic_src_cond.sv
// ---------------------------------------------------------------------------
// tb_plic_src_cond
//
// Directed bench for plic_src_cond with SOURCES=8, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. Expected values follow the build: with
// PLIC_SRC_DEBOUNCE_EN defined the latency is 6 edges and short pulses are
// rejected and flagged; without it src is the 2-stage synchronized line.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_plic_src_cond;

  localparam int SOURCES  = 8;
  localparam int SYNC     = 2;
  localparam int DEB      = 4;
  localparam int CNTB     = 3;
`ifdef PLIC_SRC_DEBOUNCE_EN
  localparam bit DEB_EN   = 1'b1;
`else
  localparam bit DEB_EN   = 1'b0;
`endif
  localparam int LAT      = SYNC + (DEB_EN ? DEB : 0);

  logic               PCLK = 1'b0;
  logic               PRESETn;
  logic [SOURCES-1:0] irq_raw;
  logic [SOURCES-1:0] pol;
  logic [SOURCES-1:0] glitch_clr;
  logic [SOURCES-1:0] src;
  logic [SOURCES-1:0] glitch;

  int checks   = 0;
  int failures = 0;

  plic_src_cond #(
    .SOURCES        (SOURCES),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_BITS       (CNTB)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .irq_raw   (irq_raw),
    .pol       (pol),
    .glitch_clr(glitch_clr),
    .src       (src),
    .glitch    (glitch)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    logic [7:0] exp_src;
    logic [7:0] exp_glitch;

    PRESETn    = 1'b0;
    irq_raw    = '0;
    pol        = '0;
    glitch_clr = '0;
    #1;
    check("reset_src", src, 8'h00);
    check("reset_glitch", glitch, 8'h00);

    // Source 2 inverted with its raw line low: x = 1 from release onward.
    pol[2] = 1'b1;
    step(2);
    check("reset_hold_src", src, 8'h00);
    PRESETn = 1'b1;
    step(LAT - 1);
    check("pol2_pre", src, 8'h00);
    step(1);
    check("pol2_rise", src, 8'h04);

    // Held step on source 0.
    irq_raw[0] = 1'b1;
    step(LAT - 1);
    check("src0_pre", src, 8'h04);
    step(1);
    check("src0_rise", src, 8'h05);
    check("src0_glitch", glitch, 8'h00);

    // 2-cycle pulse on source 1.
    irq_raw[1] = 1'b1;
    step(2);
    irq_raw[1] = 1'b0;
    step(LAT);
    check("src1_short", src, 8'h05);
    check("glitch1_set", glitch, DEB_EN ? 8'h02 : 8'h00);
    glitch_clr[1] = 1'b1;
    step(1);
    glitch_clr[1] = 1'b0;
    check("glitch1_clr", glitch, 8'h00);

    // 2-cycle pulse on source 5, traced edge by edge.
    irq_raw[5] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (k == 2) irq_raw[5] = 1'b0;
      exp_src    = 8'h05 | {2'b00, (!DEB_EN && (k == 2 || k == 3)), 5'b0};
      exp_glitch = {2'b00, (DEB_EN && k >= 5), 5'b0};
      check($sformatf("src5_k%0d", k), src, exp_src);
      check($sformatf("glitch5_k%0d", k), glitch, exp_glitch);
    end
    glitch_clr[5] = 1'b1;
    step(1);
    glitch_clr[5] = 1'b0;

    // Boundary widths: 4-cycle pulse on 6 passes, 3-cycle pulse on 7 rejected.
    irq_raw[6] = 1'b1;
    irq_raw[7] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 3) irq_raw[7] = 1'b0;
      if (k == 4) irq_raw[6] = 1'b0;
      exp_src    = 8'h05
                 | {(!DEB_EN && k >= 2 && k <= 4), 7'b0}
                 | {1'b0, (k >= LAT && k <= LAT + 3), 6'b0};
      exp_glitch = {(DEB_EN && k >= 6), 7'b0};
      check($sformatf("src67_k%0d", k), src, exp_src);
      check($sformatf("glitch67_k%0d", k), glitch, exp_glitch);
    end
    glitch_clr = 8'hFF;
    step(1);
    glitch_clr = 8'h00;
    check("glitch_all_clr", glitch, 8'h00);

    // Source 4: first glitch sets the flag, second coincides with a clear.
    irq_raw[4] = 1'b1;
    step(2);
    irq_raw[4] = 1'b0;
    step(4);
    check("glitch4_first", glitch, DEB_EN ? 8'h10 : 8'h00);
    irq_raw[4] = 1'b1;
    step(2);
    irq_raw[4] = 1'b0;
    step(2);
    glitch_clr[4] = 1'b1;
    step(1);
    glitch_clr[4] = 1'b0;
    check("glitch4_set_wins", glitch, DEB_EN ? 8'h10 : 8'h00);
    glitch_clr[4] = 1'b1;
    step(1);
    glitch_clr[4] = 1'b0;
    check("glitch4_clr", glitch, 8'h00);
    check("src4_never", src, 8'h05);

    // Source 3 held high, reset pulsed mid-qualification.
    irq_raw[3] = 1'b1;
    step(4);
    PRESETn = 1'b0;
    #2;
    check("async_reset_src", src, 8'h00);
    check("async_reset_glitch", glitch, 8'h00);
    step(1);
    PRESETn = 1'b1;
    step(LAT - 1);
    check("rerelease_pre", src, 8'h00);
    step(1);
    check("rerelease_rise", src, 8'h0D);
    check("rerelease_glitch", glitch, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/plic_src_cond.md
PLIC_SRC_COND -- requirements
Module: plic_src_cond

Interface
REQ-001 Parameter SOURCES, default 8: number of interrupt source lines conditioned.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth, legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before output change, legal range 1..2^CNT_BITS.
REQ-004 Parameter CNT_BITS, default 3: width of each per-source debounce counter.
REQ-005 PCLK  input  1  single system clock; all state updates on its rising edge.
REQ-006 PRESETn  input  1  asynchronous, active-low reset.
REQ-007 irq_raw  input  SOURCES  asynchronous raw interrupt lines from peripherals/pins.
REQ-008 pol  input  SOURCES  per-source polarity; 1 = raw line active-low (inverted before sync), 0 = active-high.
REQ-009 glitch_clr  input  SOURCES  per-source single-cycle clear of glitch flag.
REQ-010 src  output  SOURCES  conditioned, registered interrupt sources; drive plic_core src directly.
REQ-011 glitch  output  SOURCES  sticky per-source flag: rejected pulse seen.

Function
REQ-012 Per source: x = irq_raw XOR pol, fed to a SYNC_STAGES-deep flop chain; s = last stage.
REQ-013 Per source: counter cnt (CNT_BITS) and output flop src; per-source states STABLE (s == src, cnt == 0) and QUALIFY (s != src).
REQ-014 In STABLE with s != src: cnt becomes 1 and the source enters QUALIFY, unless DEBOUNCE_CYCLES == 1, in which case src takes s on that edge.
REQ-015 In QUALIFY with s != src and cnt == DEBOUNCE_CYCLES-1: src takes s, cnt clears to 0, return to STABLE.
REQ-016 In QUALIFY with s != src and cnt < DEBOUNCE_CYCLES-1: cnt increments by 1; cnt never wraps.
REQ-017 In QUALIFY with s == src: cnt clears to 0, glitch sets to 1, return to STABLE; src unchanged.
REQ-018 Latency: a change in x held stable reaches src exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges later.
REQ-019 Pulses on x shorter than DEBOUNCE_CYCLES cycles (after sync) never reach src.
REQ-020 glitch_clr[i] clears glitch[i] next edge; simultaneous set (REQ-017) and clear: set wins.
REQ-021 pol change is treated identically to an irq_raw change (passes sync and debounce).
REQ-022 Sources are fully independent; no cross-source interaction.

Reset
REQ-023 PRESETn low asynchronously forces all sync flops, cnt, src and glitch to 0.
REQ-024 Reset asserted mid-QUALIFY discards the count; after release, qualification restarts from 0.
REQ-025 After release with x = 1 held, src rises exactly SYNC_STAGES + DEBOUNCE_CYCLES edges later.

Configuration
REQ-026 Macro PLIC_SRC_DEBOUNCE_EN defined: debounce counters and glitch logic present, behaviour per REQ-013..REQ-020.
REQ-027 Macro PLIC_SRC_DEBOUNCE_EN undefined: no counters; src = s (last sync stage), latency SYNC_STAGES edges; glitch tied to 0; glitch_clr and DEBOUNCE_CYCLES/CNT_BITS ignored.

Verification (SOURCES=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-028 irq_raw[0] 0->1 held, pol=0 -> src[0] rises exactly 6 edges later, glitch[0] stays 0.
REQ-029 irq_raw[1] high for 2 cycles then low -> src[1] stays 0, glitch[1]=1 until glitch_clr[1] pulse, then 0.
REQ-030 pol[2]=1, irq_raw[2]=0 from reset release -> src[2]=1 exactly 6 edges after release.
REQ-031 irq_raw[3] held high, PRESETn pulsed low after 4 edges -> src[3]=0 immediately, rises 6 edges after release.
REQ-032 Glitch on source 4 at same edge as glitch_clr[4]=1 -> glitch[4] remains 1.
REQ-033 Macro undefined: irq_raw[5] 2-cycle pulse -> src[5] shows same 2-cycle pulse delayed 2 edges; glitch all 0.
